// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB control unit for an RV32I subset.
// Unsupported instructions park the FSM in TRAP until reset.
module multicycle_ctrl #(
    parameter int unsigned CNTWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                zero,
    output logic                ALUSrc,
    output logic [3:0]          ALUCtrl,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                loadPC,
    output logic                PCSrc,
    output logic                illegal,
    output logic [CNTWIDTH-1:0] retired
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;

    state_t      state;
    state_t      next_state;
    logic        zero_q;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        f7_base;
    logic        f7_alt;
    logic        is_r;
    logic        is_i;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        legal;
    logic        writes_rd;
    logic [3:0]  alu_op;
    logic        unused_rs;

    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign f7_base   = (funct7 == 7'b0000000);
    assign f7_alt    = (funct7 == 7'b0100000);
    assign unused_rs = ^instr[24:15];
    assign legal     = is_r | is_i | is_lw | is_sw | is_beq;
    assign writes_rd = (is_r | is_i | is_lw) & (rd != 5'd0);

    // Instruction decode: class flags are only set for supported encodings
    always_comb begin
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_beq = 1'b0;
        alu_op = ALU_ADD;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin is_r = f7_base | f7_alt; alu_op = f7_alt ? ALU_SUB : ALU_ADD; end
                    3'b001: begin is_r = f7_base; alu_op = ALU_SLL; end
                    3'b010: begin is_r = f7_base; alu_op = ALU_SLT; end
                    3'b100: begin is_r = f7_base; alu_op = ALU_XOR; end
                    3'b101: begin is_r = f7_base | f7_alt; alu_op = f7_alt ? ALU_SRA : ALU_SRL; end
                    3'b110: begin is_r = f7_base; alu_op = ALU_OR; end
                    3'b111: begin is_r = f7_base; alu_op = ALU_AND; end
                    default: ;
                endcase
            end
            OP_I: begin
                case (funct3)
                    3'b000: begin is_i = 1'b1; alu_op = ALU_ADD; end
                    3'b001: begin is_i = f7_base; alu_op = ALU_SLL; end
                    3'b010: begin is_i = 1'b1; alu_op = ALU_SLT; end
                    3'b100: begin is_i = 1'b1; alu_op = ALU_XOR; end
                    3'b101: begin is_i = f7_base | f7_alt; alu_op = f7_alt ? ALU_SRA : ALU_SRL; end
                    3'b110: begin is_i = 1'b1; alu_op = ALU_OR; end
                    3'b111: begin is_i = 1'b1; alu_op = ALU_AND; end
                    default: ;
                endcase
            end
            OP_LW: is_lw = (funct3 == 3'b010);
            OP_SW: is_sw = (funct3 == 3'b010);
            OP_BR: begin is_beq = (funct3 == 3'b000); alu_op = ALU_SUB; end
            default: ;
        endcase
    end

    // Next state and outputs; strobes are gated by rst so a reset cycle never writes
    always_comb begin
        next_state = state;
        ALUCtrl    = alu_op;
        ALUSrc     = is_i | is_lw | is_sw;
        MemToReg   = is_lw;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        loadPC     = 1'b0;
        PCSrc      = 1'b0;
        case (state)
            S_IF:  next_state = S_ID;
            S_ID:  next_state = legal ? S_EX : S_TRAP;
            S_EX:  next_state = S_MEM;
            S_MEM: begin
                next_state = S_WB;
                MemRead    = is_lw & ~rst;
                MemWrite   = is_sw & ~rst;
            end
            S_WB: begin
                next_state = S_IF;
                RegWrite   = writes_rd & ~rst;
                loadPC     = ~rst;
                PCSrc      = is_beq & zero_q & ~rst;
            end
            S_TRAP: begin
                next_state = S_TRAP;
                ALUCtrl    = ALU_AND;
            end
            default: next_state = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IF;
            zero_q  <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (state == S_EX) zero_q <= zero;
            if (state == S_WB) retired <= retired + CNTWIDTH'(1);
            if (next_state == S_TRAP) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes per-cycle expectations
// from an instruction-level model, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;
    localparam int unsigned CW = 4;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
    localparam int IDX_ADD = 0, IDX_ADDI = 9, IDX_LW = 17, IDX_SW = 18, IDX_BEQ = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instr;
    logic          zero;
    logic          ALUSrc;
    logic [3:0]    ALUCtrl;
    logic          MemRead, MemWrite, MemToReg, RegWrite, loadPC, PCSrc, illegal;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNTWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .loadPC(loadPC), .PCSrc(PCSrc),
        .illegal(illegal), .retired(retired)
    );

    typedef struct packed {
        logic          alusrc;
        logic [3:0]    aluctrl;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic          regwrite;
        logic          loadpc;
        logic          pcsrc;
        logic          illegal;
        logic [CW-1:0] retired;
        logic          m_alu;   // ALUCtrl unconstrained this cycle
        logic          m_src;   // ALUSrc/MemToReg unconstrained this cycle
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       fix_f7;
        logic [3:0] alu;
        int         kind;
    } op_t;

    op_t   ops[$];
    exp_t  q[$];
    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    int    cnt = 0;
    exp_t  mon_e;
    logic  mon_ok;

    function automatic void add_op(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                   logic fix, logic [3:0] alu, int kind);
        op_t o;
        o.op = op; o.f3 = f3; o.f7 = f7; o.fix_f7 = fix; o.alu = alu; o.kind = kind;
        ops.push_back(o);
    endfunction

    function automatic logic [31:0] build(int idx);
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = ops[idx].op;
        w[14:12] = ops[idx].f3;
        if (ops[idx].fix_f7) w[31:25] = ops[idx].f7;
        if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    function automatic logic [31:0] mk_illegal();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 8))
            0: w = 32'hFFFF_FFFF;
            1: begin w[6:0] = 7'b0110011; w[14:12] = 3'b011; w[31:25] = 7'b0000000; end
            2: begin w[6:0] = 7'b0110011; w[14:12] = 3'b001; w[31:25] = 7'b0100000; end
            3: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0000001; end
            4: begin w[6:0] = 7'b0010011; w[14:12] = 3'b011; end
            5: begin w[6:0] = 7'b0000011; w[14:12] = 3'b000; end
            6: begin w[6:0] = 7'b0100011; w[14:12] = 3'b000; end
            7: begin w[6:0] = 7'b1100011; w[14:12] = 3'b001; end
            default: begin w[6:0] = 7'b0010011; w[14:12] = 3'b101; w[31:25] = 7'b0000001; end
        endcase
        return w;
    endfunction

    function automatic exp_t base_exp();
        exp_t e;
        e = '0;
        e.retired = CW'(cnt);
        return e;
    endfunction

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One legal instruction: 5 cycles, or cut short by reset in phase ap (0 = none)
    task automatic run_word(input logic [31:0] w, input int idx, input int ap, input int zmode);
        op_t  o;
        exp_t e;
        logic zex;
        logic aborted;
        o = ops[idx];
        zex = 1'b0;
        aborted = 1'b0;
        instr = w;
        for (int p = 1; p <= 5; p++) begin
            rst  = (p == ap);
            zero = 1'($urandom_range(0, 1));
            if (p == 3) begin
                if (zmode >= 0) zero = zmode[0];
                zex = zero;
            end
            e = base_exp();
            e.aluctrl  = o.alu;
            e.alusrc   = (o.kind == K_I) || (o.kind == K_LW) || (o.kind == K_SW);
            e.memtoreg = (o.kind == K_LW);
            if (p == 4) begin
                e.memread  = (o.kind == K_LW);
                e.memwrite = (o.kind == K_SW);
            end
            if (p == 5) begin
                e.regwrite = ((o.kind == K_R) || (o.kind == K_I) || (o.kind == K_LW)) && (w[11:7] != 5'd0);
                e.loadpc   = 1'b1;
                e.pcsrc    = (o.kind == K_BEQ) && zex;
            end
            if (p == ap) begin
                e.memread = 1'b0; e.memwrite = 1'b0; e.regwrite = 1'b0;
                e.loadpc  = 1'b0; e.pcsrc    = 1'b0;
            end
            step(e);
            if (p == ap) begin
                aborted = 1'b1;
                break;
            end
        end
        rst = 1'b0;
        if (aborted) cnt = 0;
        else cnt = (cnt + 1) % (1 << CW);
    endtask

    // Unsupported word: IF, ID, t cycles of TRAP, then one TRAP cycle with rst high
    task automatic run_illegal(input logic [31:0] w, input int t);
        exp_t e;
        instr = w;
        for (int p = 1; p <= 2; p++) begin
            rst  = 1'b0;
            zero = 1'($urandom_range(0, 1));
            e = base_exp();
            e.m_alu = 1'b1;
            e.m_src = 1'b1;
            step(e);
        end
        for (int k = 0; k <= t; k++) begin
            rst  = (k == t);
            zero = 1'($urandom_range(0, 1));
            e = base_exp();
            e.illegal = 1'b1;
            e.m_src   = 1'b1;
            step(e);
        end
        rst = 1'b0;
        cnt = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) begin
            mon_e  = q.pop_front();
            mon_ok = (MemRead == mon_e.memread) && (MemWrite == mon_e.memwrite) &&
                     (RegWrite == mon_e.regwrite) && (loadPC == mon_e.loadpc) &&
                     (PCSrc == mon_e.pcsrc) && (illegal == mon_e.illegal) &&
                     (retired == mon_e.retired) &&
                     (mon_e.m_alu || (ALUCtrl == mon_e.aluctrl)) &&
                     (mon_e.m_src || ((ALUSrc == mon_e.alusrc) && (MemToReg == mon_e.memtoreg)));
            checks++;
            if (mon_ok) passed++;
            else $display("FAIL cycle_check cyc=%0d instr=%h: got rd/wr/rw/ld/pcs/ill=%b%b%b%b%b%b alu=%b src=%b m2r=%b ret=%0d, expected %b%b%b%b%b%b alu=%b src=%b m2r=%b ret=%0d",
                          cyc, instr, MemRead, MemWrite, RegWrite, loadPC, PCSrc, illegal,
                          ALUCtrl, ALUSrc, MemToReg, retired,
                          mon_e.memread, mon_e.memwrite, mon_e.regwrite, mon_e.loadpc,
                          mon_e.pcsrc, mon_e.illegal, mon_e.aluctrl, mon_e.alusrc,
                          mon_e.memtoreg, mon_e.retired);
            checks++;
            if ((MemRead & MemWrite) == 1'b0) passed++;
            else $display("FAIL strobe_excl cyc=%0d: MemRead and MemWrite both high", cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   r;
        int   idx;
        add_op(7'b0110011, 3'b000, 7'b0000000, 1'b1, 4'b0010, K_R);  // ADD
        add_op(7'b0110011, 3'b000, 7'b0100000, 1'b1, 4'b0110, K_R);  // SUB
        add_op(7'b0110011, 3'b111, 7'b0000000, 1'b1, 4'b0000, K_R);  // AND
        add_op(7'b0110011, 3'b110, 7'b0000000, 1'b1, 4'b0001, K_R);  // OR
        add_op(7'b0110011, 3'b100, 7'b0000000, 1'b1, 4'b0101, K_R);  // XOR
        add_op(7'b0110011, 3'b001, 7'b0000000, 1'b1, 4'b1001, K_R);  // SLL
        add_op(7'b0110011, 3'b101, 7'b0000000, 1'b1, 4'b1000, K_R);  // SRL
        add_op(7'b0110011, 3'b101, 7'b0100000, 1'b1, 4'b1010, K_R);  // SRA
        add_op(7'b0110011, 3'b010, 7'b0000000, 1'b1, 4'b0111, K_R);  // SLT
        add_op(7'b0010011, 3'b000, 7'b0000000, 1'b0, 4'b0010, K_I);  // ADDI
        add_op(7'b0010011, 3'b111, 7'b0000000, 1'b0, 4'b0000, K_I);  // ANDI
        add_op(7'b0010011, 3'b110, 7'b0000000, 1'b0, 4'b0001, K_I);  // ORI
        add_op(7'b0010011, 3'b100, 7'b0000000, 1'b0, 4'b0101, K_I);  // XORI
        add_op(7'b0010011, 3'b010, 7'b0000000, 1'b0, 4'b0111, K_I);  // SLTI
        add_op(7'b0010011, 3'b001, 7'b0000000, 1'b1, 4'b1001, K_I);  // SLLI
        add_op(7'b0010011, 3'b101, 7'b0000000, 1'b1, 4'b1000, K_I);  // SRLI
        add_op(7'b0010011, 3'b101, 7'b0100000, 1'b1, 4'b1010, K_I);  // SRAI
        add_op(7'b0000011, 3'b010, 7'b0000000, 1'b0, 4'b0010, K_LW);
        add_op(7'b0100011, 3'b010, 7'b0000000, 1'b0, 4'b0010, K_SW);
        add_op(7'b1100011, 3'b000, 7'b0000000, 1'b0, 4'b0110, K_BEQ);

        rst   = 1'b1;
        zero  = 1'b0;
        instr = 32'h0020_81B3;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = base_exp();
            e.aluctrl = 4'b0010;
            step(e);
        end
        rst = 1'b0;

        run_word(32'h0020_81B3, IDX_ADD, 0, -1);       // ADD x3,x1,x2
        run_word(32'h0080_2283, IDX_LW, 0, -1);        // LW x5,8(x0)
        run_word(32'h0050_2623, IDX_SW, 0, -1);        // SW x5,12(x0)
        run_word(32'h0020_8463, IDX_BEQ, 0, 1);        // BEQ taken
        run_word(32'h0020_8463, IDX_BEQ, 0, 0);        // BEQ not taken
        run_word(32'h0050_2623, IDX_SW, 4, -1);        // reset during MEM of SW
        run_word(32'h0020_81B3, IDX_ADD, 0, -1);
        run_illegal(32'hFFFF_FFFF, 20);
        run_word(32'h0010_8093, IDX_ADDI, 0, -1);      // ADDI x1,x1,1
        run_word(32'h0010_8093, IDX_ADDI, 5, -1);      // reset during WB
        for (int i = 0; i < 16; i++) run_word(32'h0010_8093, IDX_ADDI, 0, -1);
        run_word(32'h0020_81B3, IDX_ADD, 0, -1);       // retired must read 0 after wrap

        for (int n = 0; n < 200; n++) begin
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, ops.size() - 1);
            if (r == 0)      run_illegal(mk_illegal(), $urandom_range(1, 5));
            else if (r == 1) run_word(build(idx), idx, $urandom_range(1, 5), -1);
            else             run_word(build(idx), idx, 0, -1);
        end

        @(posedge clk);
        #1;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: %0d expectations never compared", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        if (passed == checks) $display("PASS");
        else $display("FAIL summary: %0d mismatches", checks - passed);
        $finish;
    end
endmodule
